// File: rtl/div_radix2_iter_pkg.sv
// Shared state codes and handshake levels for the iterative radix-2 divider.
package div_radix2_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_radix2_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// returns {remainder, quotient} under a start/ready handshake with EX.
module div_radix2_iter
    import div_radix2_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   rq_q, rq_d;         // {partial remainder, dividend/quotient}
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_abs, op2_abs;
    logic [WIDTH:0]       rem_shift, diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_next, quo_next;
    logic                 abort;

    always_comb begin
        op1_neg   = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg   = signed_div_i & opdata2_i[WIDTH-1];
        // Magnitude of the most negative value wraps to itself, read as unsigned.
        op1_abs   = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_abs   = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

        rem_shift = {rq_q[2*WIDTH-1:WIDTH], rq_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor_q};
        q_bit     = (rem_shift >= {1'b0, divisor_q});
        rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {rq_q[WIDTH-2:0], q_bit};
        abort     = annul_i | (start_i == DivStop);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rq_d      = rq_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DivFree: begin
                ready_d = DivResultNotReady;
                if ((start_i == DivStart) && !annul_i) begin
                    cnt_d     = '0;
                    divisor_d = op2_abs;
                    q_neg_d   = op1_neg ^ op2_neg;
                    r_neg_d   = op1_neg;
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                        rq_d    = {{WIDTH{1'b0}}, opdata1_i};
                    end else begin
                        state_d = DivOn;
                        rq_d    = {{WIDTH{1'b0}}, op1_abs};
                    end
                end
            end
            DivByZero: begin
                if (abort) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = {rq_q[WIDTH-1:0], {WIDTH{1'b1}}};
                    ready_d  = DivResultReady;
                end
            end
            DivOn: begin
                if (abort) begin
                    state_d = DivFree;
                end else begin
                    rq_d  = {rem_next, quo_next};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DivEnd;
                        ready_d  = DivResultReady;
                        result_d = {r_neg_q ? (~rem_next + 1'b1) : rem_next,
                                    q_neg_q ? (~quo_next + 1'b1) : quo_next};
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end
            end
            default: begin
                state_d = DivFree;
                ready_d = DivResultNotReady;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rq_q      <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rq_q      <= rq_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_radix2_iter.sv
// Self-checking bench for div_radix2_iter: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_div_radix2_iter;

    logic        clk;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    div_radix2_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Quotient truncates toward zero, remainder follows the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int hold);
        int edges;
        int exp_lat;
        exp_lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 3) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
        end while (!ready_o && edges < 100);
        chk({tag, " latency"}, 64'(edges), 64'(exp_lat));
        chk({tag, " result"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " ready held"}, 64'(ready_o), 64'd1);
            chk({tag, " result held"}, result_o, exp);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " ready pulse end"}, 64'(ready_o), 64'd0);
        chk({tag, " result kept"}, result_o, exp);
    endtask

    initial begin
        logic [63:0] prev;
        logic        sgn;
        logic [31:0] a, b;
        int          seen;

        resetn       = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 2);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 0);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0);
        run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
        run_div("div min/1", 1'b1, 32'h8000_0000, 32'd1, {32'd0, 32'h8000_0000}, 0);
        run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);

        // Flush at iteration 10: no ready, result untouched.
        prev = result_o;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        chk("annul no ready", 64'(seen), 64'd0);
        chk("annul result unchanged", result_o, prev);
        run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

        // Asynchronous reset between edges in the middle of an iteration.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async reset ready", 64'(ready_o), 64'd0);
        chk("async reset result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_div("divu 1000/7 after reset", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 0);

        // Back-to-back: run_div re-raises start the cycle after returning to idle.
        run_div("b2b first", 1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 0);
        run_div("b2b second", 1'b1, 32'hFFFF_FF9C, 32'd9,
                {32'hFFFF_FFFF, 32'hFFFF_FFF5}, 0);

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            run_div($sformatf("rand%0d", i), sgn, a, b, ref_div(sgn, a, b), i % 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
